// File: rtl/gsram_pkg.sv
// Shared constants and types for the GSRAM arbiter slice.
// Requester indices name the default datapath clients.
package gsram_pkg;

    localparam int GSRAM_ROWS   = 10;
    localparam int GSRAM_COLS   = 10;
    localparam int GSRAM_ADDR_W = 4;
    localparam int GSRAM_DATA_W = 16;

    localparam int REQ_MAC  = 0;
    localparam int REQ_LUT  = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic {
        ARB_OPEN = 1'b0,
        ARB_HELD = 1'b1
    } arb_state_e;

    function automatic logic addr_in_range(input logic [GSRAM_ADDR_W-1:0] a,
                                           input int unsigned             lim);
        return {{(32-GSRAM_ADDR_W){1'b0}}, a} < lim;
    endfunction

endpackage

// File: rtl/gsram_prio_pick.sv
// Combinational one-hot picker: first set req bit found when scanning
// upward (with wrap) from the start index.
module gsram_prio_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(start) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gsram_arbiter.sv
// Single-port GSRAM arbiter with lockable ownership for atomic RMW bursts.
// Build option: define GSRAM_ARB_ROUND_ROBIN_EN for rotating priority.
module gsram_arbiter
    import gsram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = GSRAM_DATA_W,
    parameter int ROWS    = GSRAM_ROWS,
    parameter int COLS    = GSRAM_COLS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*4-1:0]        row,
    input  logic [NUM_REQ*4-1:0]        col,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        addr_err,
    output logic                        sram_en,
    output logic                        sram_we,
    output logic [3:0]                  sram_row,
    output logic [3:0]                  sram_col,
    output logic [DATA_W-1:0]           sram_wdata,
    input  logic [DATA_W-1:0]           sram_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int AW    = GSRAM_ADDR_W;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   start;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt_int;
    logic               any_gnt;

    logic [IDX_W-1:0]   win;
    logic [AW-1:0]      win_row, win_col;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_we, win_lock, win_ok;

    logic               sram_en_q, sram_en_d;
    logic               sram_we_q, sram_we_d;
    logic [AW-1:0]      sram_row_q, sram_row_d;
    logic [AW-1:0]      sram_col_q, sram_col_d;
    logic [DATA_W-1:0]  sram_wdata_q, sram_wdata_d;
    logic               addr_err_q, addr_err_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
    logic               rd_err_q, rd_err_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic               rd_err2_q, rd_err2_d;

`ifdef GSRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (state_q == ARB_OPEN && any_gnt)
            rr_d = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_q <= '0;
        else        rr_q <= rr_d;
    end

    assign start = rr_q;
`else
    assign start = '0;
`endif

    gsram_prio_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req   (req),
        .start (start),
        .gnt   (pick)
    );

    // Grant is masked during reset so nothing can be accepted and then lost.
    always_comb begin
        gnt_int = '0;
        if (reset) begin
            if (state_q == ARB_OPEN)
                gnt_int = pick;
            else if (req[owner_q])
                gnt_int[owner_q] = 1'b1;
        end
    end

    assign gnt     = gnt_int;
    assign any_gnt = |gnt_int;

    always_comb begin
        win       = '0;
        win_row   = '0;
        win_col   = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        win_lock  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_int[i]) begin
                win       = IDX_W'(i);
                win_row   = row[i*AW +: AW];
                win_col   = col[i*AW +: AW];
                win_wdata = wdata[i*DATA_W +: DATA_W];
                win_we    = we[i];
                win_lock  = lock[i];
            end
        end
        win_ok = addr_in_range(win_row, ROWS) && addr_in_range(win_col, COLS);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_OPEN: begin
                if (any_gnt && win_lock) begin
                    state_d = ARB_HELD;
                    owner_d = win;
                end
            end
            ARB_HELD: begin
                // Releasing lock ends ownership whether or not the owner is requesting.
                if (!lock[owner_q])
                    state_d = ARB_OPEN;
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    always_comb begin
        sram_en_d    = any_gnt && win_ok;
        sram_we_d    = any_gnt && win_we;
        sram_row_d   = any_gnt ? win_row   : sram_row_q;
        sram_col_d   = any_gnt ? win_col   : sram_col_q;
        sram_wdata_d = any_gnt ? win_wdata : sram_wdata_q;
        addr_err_d   = any_gnt && !win_ok;
        rd_pend_d    = (any_gnt && !win_we) ? gnt_int : '0;
        rd_err_d     = any_gnt && !win_ok;
        rvalid_d     = rd_pend_q;
        rd_err2_d    = rd_err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_OPEN;
            owner_q      <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_row_q   <= '0;
            sram_col_q   <= '0;
            sram_wdata_q <= '0;
            addr_err_q   <= 1'b0;
            rd_pend_q    <= '0;
            rd_err_q     <= 1'b0;
            rvalid_q     <= '0;
            rd_err2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_row_q   <= sram_row_d;
            sram_col_q   <= sram_col_d;
            sram_wdata_q <= sram_wdata_d;
            addr_err_q   <= addr_err_d;
            rd_pend_q    <= rd_pend_d;
            rd_err_q     <= rd_err_d;
            rvalid_q     <= rvalid_d;
            rd_err2_q    <= rd_err2_d;
        end
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_row   = sram_row_q;
    assign sram_col   = sram_col_q;
    assign sram_wdata = sram_wdata_q;
    assign addr_err   = addr_err_q;
    assign rvalid     = rvalid_q;
    // Macro data arrives in the rvalid cycle; errored reads return zero.
    assign rdata      = (|rvalid_q && !rd_err2_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_gsram_arbiter.sv
// Directed bench for gsram_arbiter with a write-first GSRAM model.
// Honours GSRAM_ARB_ROUND_ROBIN_EN for the priority-order vectors.
module tb_gsram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [11:0] row, col;
    logic [47:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        addr_err, sram_en, sram_we;
    logic [3:0]  sram_row, sram_col;
    logic [15:0] sram_wdata, sram_rdata;
    logic [15:0] mem [0:15][0:15];

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    gsram_arbiter #(.NUM_REQ(3), .DATA_W(16), .ROWS(10), .COLS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .we         (we),
        .row        (row),
        .col        (col),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .addr_err   (addr_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_row   (sram_row),
        .sram_col   (sram_col),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Write-first single-port macro: read data one cycle after sram_en.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    mem[i][j] <= '0;
            sram_rdata <= '0;
        end else if (sram_en) begin
            if (sram_we) begin
                mem[sram_row][sram_col] <= sram_wdata;
                sram_rdata              <= sram_wdata;
            end else begin
                sram_rdata <= mem[sram_row][sram_col];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] i, input logic r, input logic l, input logic w,
                         input logic [3:0] rw, input logic [3:0] cl, input logic [15:0] d);
        req[i]               = r;
        lock[i]              = l;
        we[i]                = w;
        row[{i, 2'b00} +: 4] = rw;
        col[{i, 2'b00} +: 4] = cl;
        wdata[{i, 4'h0} +: 16] = d;
    endtask

    task automatic clear_all();
        req = '0; lock = '0; we = '0; row = '0; col = '0; wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        clear_all();
        req = 3'b111;
        repeat (3) tick();
        settle();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_en", 32'(sram_en), 32'h0);
        chk("rst_row", 32'(sram_row), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        clear_all();
        reset = 1'b1;
        tick();

        // Write (9,9) then read it back
        drive(2'd1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 16'h1234);
        settle();
        chk("wr99_gnt", 32'(gnt), 32'h2);
        tick();
        chk("wr99_en", 32'(sram_en), 32'h1);
        chk("wr99_we", 32'(sram_we), 32'h1);
        chk("wr99_row", 32'(sram_row), 32'h9);
        chk("wr99_col", 32'(sram_col), 32'h9);
        chk("wr99_wdata", 32'(sram_wdata), 32'h1234);
        drive(2'd1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 16'h0);
        settle();
        chk("rd99_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rd99_en", 32'(sram_en), 32'h1);
        chk("rd99_we", 32'(sram_we), 32'h0);
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        clear_all();
        tick();
        chk("rd99_rvalid", 32'(rvalid), 32'h2);
        chk("rd99_rdata", 32'(rdata), 32'h1234);
        chk("idle_en", 32'(sram_en), 32'h0);
        chk("idle_row_hold", 32'(sram_row), 32'h9);
        tick();

        // Out-of-range read (10,0)
        drive(2'd2, 1'b1, 1'b0, 1'b0, 4'd10, 4'd0, 16'h0);
        settle();
        chk("oor_gnt", 32'(gnt), 32'h4);
        tick();
        chk("oor_en", 32'(sram_en), 32'h0);
        chk("oor_err", 32'(addr_err), 32'h1);
        clear_all();
        tick();
        chk("oor_err_pulse", 32'(addr_err), 32'h0);
        chk("oor_rvalid", 32'(rvalid), 32'h4);
        chk("oor_rdata", 32'(rdata), 32'h0);
        tick();

        // Req 0 and req 2 contend for 4 cycles
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
            drive(2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 16'h0);
            settle();
`ifdef GSRAM_ARB_ROUND_ROBIN_EN
            chk("prio_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h4);
`else
            chk("prio_gnt", 32'(gnt), 32'h1);
`endif
            tick();
        end
        clear_all();
        tick();
        tick();

        // Locked read-modify-write by requester 1 against requester 0
        drive(2'd1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd3, 16'h0);
        settle();
        chk("rmw_rd_gnt", 32'(gnt), 32'h2);
        tick();
        drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
        drive(2'd1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 16'h0);
        settle();
        chk("rmw_hold_gnt", 32'(gnt), 32'h0);
        tick();
        chk("rmw_rvalid", 32'(rvalid), 32'h2);
        chk("rmw_rdata_old", 32'(rdata), 32'h0);
        drive(2'd1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 16'h00A5);
        settle();
        chk("rmw_wr_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rmw_wr_we", 32'(sram_we), 32'h1);
        chk("rmw_wr_row", 32'(sram_row), 32'h2);
        chk("rmw_wr_col", 32'(sram_col), 32'h3);
        chk("rmw_wr_wdata", 32'(sram_wdata), 32'h00A5);
        drive(2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
        settle();
        chk("rmw_release_gnt", 32'(gnt), 32'h1);
        tick();
        drive(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
        drive(2'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 16'h0);
        settle();
        chk("rmw_rd2_gnt", 32'(gnt), 32'h2);
        tick();
        clear_all();
        chk("req0_rvalid", 32'(rvalid), 32'h1);
        tick();
        chk("rmw_rd2_rvalid", 32'(rvalid), 32'h2);
        chk("rmw_rd2_rdata", 32'(rdata), 32'h00A5);
        tick();

        // Owner holds lock with req low
        drive(2'd2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 16'h0);
        settle();
        chk("held_lock_gnt", 32'(gnt), 32'h4);
        for (int k = 0; k < 3; k++) begin
            tick();
            drive(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 16'h0);
            drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
            settle();
            chk("held_idle_gnt", 32'(gnt), 32'h0);
            if (k > 0) chk("held_idle_en", 32'(sram_en), 32'h0);
        end
        tick();
        drive(2'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
        settle();
        chk("held_unlock_gnt", 32'(gnt), 32'h0);
        tick();
        chk("after_unlock_gnt", 32'(gnt), 32'h1);
        clear_all();
        tick();
        tick();
        tick();

        // Reset asserted while a read is in flight
        drive(2'd1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 16'h0);
        settle();
        chk("inflight_gnt", 32'(gnt), 32'h2);
        tick();
        chk("inflight_en", 32'(sram_en), 32'h1);
        clear_all();
        req = 3'b001;
        reset = 1'b0;
        settle();
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_en", 32'(sram_en), 32'h0);
        chk("midrst_row", 32'(sram_row), 32'h0);
        chk("midrst_col", 32'(sram_col), 32'h0);
        tick();
        chk("midrst_rvalid", 32'(rvalid), 32'h0);
        clear_all();
        reset = 1'b1;
        tick();
        chk("postrst_rvalid", 32'(rvalid), 32'h0);
        drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
        settle();
        chk("postrst_gnt", 32'(gnt), 32'h1);
        clear_all();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
